// File: rtl/led_sequencer.sv
// led_sequencer: memory-mapped LED pattern engine with static, blink,
// rotate and bounce modes, stepped by a prescaled tick counter.
module led_sequencer #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] slave_address,
    input  logic       slave_write,
    input  logic [7:0] slave_writedata,
    input  logic       slave_read,
    output logic [7:0] slave_readdata,
    output logic [7:0] user_dataout_0
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    // Register file
    logic [7:0]  r_pattern;
    mode_t       r_mode;
    logic [7:0]  r_period;
    logic        r_enable;

    // Sequencing state
    logic [15:0] r_prescale;
    logic [7:0]  r_stepcnt;
    dir_t        r_dir;
    logic        r_phase;
    logic [7:0]  r_out;
    logic [7:0]  r_readdata;

    // Decode / next-state wires
    logic        w_wr_pattern;
    logic        w_wr_mode;
    logic        w_wr_period;
    logic        w_wr_control;
    logic        w_load;
    logic        w_tick;
    logic        w_step;
    logic [7:0]  w_load_value;
    logic [7:0]  w_read_value;
    logic [7:0]  w_next_out;
    dir_t        w_next_dir;
    logic        w_next_phase;

    // Bus decode, load detection and tick/step qualification
    always_comb begin
        w_wr_pattern = slave_write && (slave_address == 4'd0);
        w_wr_mode    = slave_write && (slave_address == 4'd1);
        w_wr_period  = slave_write && (slave_address == 4'd2);
        w_wr_control = slave_write && (slave_address == 4'd3);
        w_load       = w_wr_pattern || w_wr_mode || w_wr_period ||
                       (w_wr_control && slave_writedata[1]);
        // A pattern written in the same cycle is the value that gets loaded
        w_load_value = w_wr_pattern ? slave_writedata : r_pattern;
        w_tick       = r_enable && (r_prescale == PS_LAST);
        w_step       = w_tick && (r_stepcnt == r_period);
    end

    // Read mux: unmapped addresses and unused bits read as zero
    always_comb begin
        case (slave_address)
            4'd0:    w_read_value = r_pattern;
            4'd1:    w_read_value = {6'b0, r_mode};
            4'd2:    w_read_value = r_period;
            4'd3:    w_read_value = {7'b0, r_enable};
            4'd4:    w_read_value = {6'b0, r_dir, r_enable};
            default: w_read_value = '0;
        endcase
    end

    // Output value produced by one step in the current mode
    always_comb begin
        w_next_out   = r_out;
        w_next_dir   = r_dir;
        w_next_phase = r_phase;
        case (r_mode)
            MODE_STATIC: begin
                w_next_out = r_out;
            end
            MODE_BLINK: begin
                w_next_out   = r_phase ? 8'h00 : r_pattern;
                w_next_phase = ~r_phase;
            end
            MODE_ROTATE: begin
                w_next_out = {r_out[6:0], r_out[7]};
            end
            MODE_BOUNCE: begin
                if ((r_dir == DIR_LEFT) && r_out[7]) begin
                    w_next_dir = DIR_RIGHT;
                    w_next_out = {1'b0, r_out[7:1]};
                end else if ((r_dir == DIR_RIGHT) && r_out[0]) begin
                    w_next_dir = DIR_LEFT;
                    w_next_out = {r_out[6:0], 1'b0};
                end else if (r_dir == DIR_LEFT) begin
                    w_next_out = {r_out[6:0], 1'b0};
                end else begin
                    w_next_out = {1'b0, r_out[7:1]};
                end
            end
            default: begin
                w_next_out = r_out;
            end
        endcase
    end

    // Software-visible configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= '0;
            r_mode    <= MODE_STATIC;
            r_period  <= '0;
            r_enable  <= 1'b0;
        end else begin
            if (w_wr_pattern) r_pattern <= slave_writedata;
            if (w_wr_mode)    r_mode    <= mode_t'(slave_writedata[1:0]);
            if (w_wr_period)  r_period  <= slave_writedata;
            if (w_wr_control) r_enable  <= slave_writedata[0];
        end
    end

    // Prescaler and step counter; frozen while disabled, cleared on load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_stepcnt  <= '0;
        end else if (w_load) begin
            r_prescale <= '0;
            r_stepcnt  <= '0;
        end else if (r_enable) begin
            r_prescale <= w_tick ? 16'd0 : r_prescale + 16'd1;
            if (w_tick) begin
                r_stepcnt <= w_step ? 8'd0 : r_stepcnt + 8'd1;
            end
        end
    end

    // LED output, bounce direction and blink phase; a load overrides a step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= '0;
            r_dir   <= DIR_LEFT;
            r_phase <= 1'b1;
        end else if (w_load) begin
            r_out   <= w_load_value;
            r_dir   <= DIR_LEFT;
            r_phase <= 1'b1;
        end else if (w_step) begin
            r_out   <= w_next_out;
            r_dir   <= w_next_dir;
            r_phase <= w_next_phase;
        end
    end

    // Registered read data, captured from pre-write register values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (slave_read) begin
            r_readdata <= w_read_value;
        end
    end

    assign slave_readdata = r_readdata;
    assign user_dataout_0 = r_out;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed scenarios plus randomized bus traffic, checked
// every cycle against a step-count based reference model.
module tb_led_sequencer;

    localparam int unsigned PRESCALE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] slave_address;
    logic       slave_write;
    logic [7:0] slave_writedata;
    logic       slave_read;
    logic [7:0] slave_readdata;
    logic [7:0] user_dataout_0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_sequencer #(.PRESCALE(PRESCALE)) dut (
        .clk             (clk),
        .reset           (reset),
        .slave_address   (slave_address),
        .slave_write     (slave_write),
        .slave_writedata (slave_writedata),
        .slave_read      (slave_read),
        .slave_readdata  (slave_readdata),
        .user_dataout_0  (user_dataout_0)
    );

    // Reference model: outputs derived from enabled-cycle count and the
    // number of steps since the last load.
    typedef struct packed {
        logic [7:0] pattern;
        logic [1:0] mode;
        logic [7:0] period;
        logic       enable;
        logic       dir;
        logic [7:0] out;
        logic [7:0] rd;
        int         run;
        int         steps;
    } model_t;

    model_t m;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << (n % 8);
        return d[15:8];
    endfunction

    function automatic logic [7:0] read_reg(input model_t s, input logic [3:0] a);
        case (a)
            4'd0:    return s.pattern;
            4'd1:    return {6'b0, s.mode};
            4'd2:    return s.period;
            4'd3:    return {7'b0, s.enable};
            4'd4:    return {6'b0, s.dir, s.enable};
            default: return 8'h00;
        endcase
    endfunction

    function automatic model_t next_model(input model_t s, input logic wr,
                                          input logic rd, input logic [3:0] a,
                                          input logic [7:0] wd);
        model_t n;
        logic   load;
        int     interval;
        n = s;
        if (rd) n.rd = read_reg(s, a);
        load = wr && ((a <= 4'd2) || ((a == 4'd3) && wd[1]));
        if (wr) begin
            case (a)
                4'd0:    n.pattern = wd;
                4'd1:    n.mode    = wd[1:0];
                4'd2:    n.period  = wd;
                4'd3:    n.enable  = wd[0];
                default: ;
            endcase
        end
        if (load) begin
            n.run   = 0;
            n.steps = 0;
            n.out   = n.pattern;
            n.dir   = 1'b0;
        end else if (s.enable) begin
            n.run    = s.run + 1;
            interval = (int'(s.period) + 1) * int'(PRESCALE);
            if (n.run % interval == 0) begin
                n.steps = s.steps + 1;
                case (s.mode)
                    2'd0: n.out = s.pattern;
                    2'd1: n.out = (n.steps % 2 == 1) ? 8'h00 : s.pattern;
                    2'd2: n.out = rotl(s.pattern, n.steps);
                    default: begin
                        if (!s.dir && s.out[7]) begin
                            n.dir = 1'b1;
                            n.out = s.out >> 1;
                        end else if (s.dir && s.out[0]) begin
                            n.dir = 1'b0;
                            n.out = s.out << 1;
                        end else begin
                            n.out = s.dir ? (s.out >> 1) : (s.out << 1);
                        end
                    end
                endcase
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= next_model(m, slave_write, slave_read, slave_address, slave_writedata);
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("out_vs_model", user_dataout_0, m.out);
        check("readdata_vs_model", slave_readdata, m.rd);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        tick();
        slave_write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        slave_address = a;
        slave_read    = 1'b1;
        tick();
        slave_read    = 1'b0;
    endtask

    task automatic rw(input logic [3:0] a, input logic [7:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        slave_read      = 1'b1;
        tick();
        slave_write     = 1'b0;
        slave_read      = 1'b0;
    endtask

    logic [7:0] bounce_exp [9];
    int         skip;
    logic [3:0] ra;
    logic [7:0] rdat;

    initial begin
        reset           = 1'b0;
        slave_address   = '0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        slave_read      = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check("reset_out", user_dataout_0, 8'h00);
        check("reset_rd", slave_readdata, 8'h00);

        // Static mode and read-back
        wr(4'd1, 8'h00);
        wr(4'd0, 8'hA5);
        check("static_out", user_dataout_0, 8'hA5);
        check("model_static_out", m.out, 8'hA5);
        rd(4'd0);
        check("read_pattern", slave_readdata, 8'hA5);

        // Simultaneous read and write returns the old value
        rw(4'd0, 8'h3C);
        check("rw_old_value", slave_readdata, 8'hA5);
        check("rw_new_out", user_dataout_0, 8'h3C);
        rd(4'd0);
        check("read_new_pattern", slave_readdata, 8'h3C);

        // Reset asserted mid-cycle clears outputs before the next edge
        #1 reset = 1'b1;
        #1;
        check("midreset_out", user_dataout_0, 8'h00);
        check("midreset_rd", slave_readdata, 8'h00);
        @(posedge clk);
        #2 reset = 1'b0;
        rd(4'd4);
        check("status_after_reset", slave_readdata, 8'h00);
        repeat (5) tick();
        check("idle_after_reset", user_dataout_0, 8'h00);

        // Rotate, PERIOD=1: step every 8 cycles
        wr(4'd0, 8'h81);
        wr(4'd1, 8'h02);
        wr(4'd2, 8'h01);
        wr(4'd3, 8'h01);
        check("rot_start", user_dataout_0, 8'h81);
        repeat (7) tick();
        check("rot_before_step", user_dataout_0, 8'h81);
        tick();
        check("rot_step1", user_dataout_0, 8'h03);
        check("model_rot_step1", m.out, 8'h03);
        repeat (8) tick();
        check("rot_step2", user_dataout_0, 8'h06);

        // Pattern write on the cycle a step is due wins over the step
        repeat (7) tick();
        wr(4'd0, 8'h11);
        check("load_beats_step", user_dataout_0, 8'h11);
        check("model_load_beats_step", m.out, 8'h11);
        repeat (7) tick();
        check("after_load_hold", user_dataout_0, 8'h11);
        tick();
        check("after_load_step", user_dataout_0, 8'h22);

        // Bounce, PERIOD=0: step every 4 cycles
        bounce_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        wr(4'd0, 8'h40);
        wr(4'd1, 8'h03);
        wr(4'd2, 8'h00);
        skip = 0;
        for (int i = 0; i < 9; i++) begin
            repeat (4 - skip) tick();
            skip = 0;
            check("bounce_step", user_dataout_0, bounce_exp[i]);
            if (i == 1 || i == 8) begin
                rd(4'd4);
                check("bounce_status", slave_readdata, (i == 1) ? 8'h03 : 8'h01);
                skip = 1;
            end
        end

        // Blink with pause and resume
        wr(4'd1, 8'h01);
        wr(4'd0, 8'h0F);
        wr(4'd2, 8'h00);
        repeat (4) tick();
        check("blink_step1", user_dataout_0, 8'h00);
        check("model_blink_step1", m.out, 8'h00);
        repeat (4) tick();
        check("blink_step2", user_dataout_0, 8'h0F);
        wr(4'd3, 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("blink_paused", user_dataout_0, 8'h0F);
        end
        wr(4'd3, 8'h01);
        repeat (3) tick();
        check("blink_resume", user_dataout_0, 8'h00);

        // Zero pattern in rotate and bounce stays zero
        wr(4'd0, 8'h00);
        wr(4'd1, 8'h02);
        repeat (16) tick();
        check("zero_rotate", user_dataout_0, 8'h00);
        wr(4'd1, 8'h03);
        repeat (16) tick();
        check("zero_bounce", user_dataout_0, 8'h00);

        // Restart via CONTROL bit1 reloads the pattern
        wr(4'd0, 8'h01);
        wr(4'd1, 8'h02);
        repeat (12) tick();
        wr(4'd3, 8'h03);
        check("restart_reload", user_dataout_0, 8'h01);
        rd(4'd3);
        check("control_read", slave_readdata, 8'h01);

        // Randomized bus traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 5) begin
                ra = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                                 : 4'($urandom_range(0, 4));
                case (ra)
                    4'd2:    rdat = 8'($urandom_range(0, 2));
                    4'd3:    rdat = {6'($urandom), ($urandom_range(0, 3) == 0),
                                     ($urandom_range(0, 3) != 0)};
                    default: rdat = 8'($urandom);
                endcase
                slave_address   = ra;
                slave_writedata = rdat;
                slave_write     = 1'b1;
            end else begin
                slave_address = 4'($urandom_range(0, 5));
            end
            slave_read = ($urandom_range(0, 3) == 0);
            tick();
            slave_write = 1'b0;
            slave_read  = 1'b0;
            if ($urandom_range(0, 999) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
                @(posedge clk);
                #2;
            end
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
